// File: rtl/seven_seg_pkg.sv
// Shared types and active-low segment patterns for the multiplexed seven-segment driver.
package seven_seg_pkg;

   typedef logic [6:0] seg_t;
   typedef logic [3:0] nibble_t;

   localparam seg_t SEG_OFF = 7'h7F;

   // Index is the hex value; bit order {g,f,e,d,c,b,a}, 0 = segment lit.
   localparam seg_t SEG_LUT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seven_seg_decoder
   import seven_seg_pkg::*;
(
   input  nibble_t nibble,
   output seg_t    seg
);

   assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/seven_seg_mux.sv
// N-digit time-multiplexed seven-segment scanner with dead time and per-digit blanking.
// Define SEVEN_SEG_LZ_SUPPRESS_EN to also blank leading zeros (digit 0 always shown).
module seven_seg_mux
   import seven_seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 2,
   parameter int unsigned SLOT_CYCLES = 24000,
   parameter int unsigned DEAD_CYCLES = 240
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [4*NUM_DIGITS-1:0]   digits,
   input  logic [NUM_DIGITS-1:0]     blank,
   output logic [6:0]                seg,
   output logic [NUM_DIGITS-1:0]     anode,
   output logic                      frame
);

   localparam int unsigned CW = $clog2(SLOT_CYCLES);
   localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   nibble_t               nibble_q, nibble_d;
   logic                  blank_q, blank_d;
   logic [NUM_DIGITS-1:0] blank_eff;
   logic                  dead_done;
   logic                  active;
   seg_t                  seg_dec;

`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
   logic [NUM_DIGITS-1:0] lz;

   // Walk from the most significant digit down; a digit is a leading zero while
   // it and everything above it are zero.
   always_comb begin
      logic all_zero;
      all_zero = 1'b1;
      lz       = '0;
      for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
         all_zero = all_zero & (digits[4*k +: 4] == 4'h0);
         if (k > 0) lz[k] = all_zero;
      end
   end

   assign blank_eff = blank | lz;
`else
   assign blank_eff = blank;
`endif

   always_comb begin
      cnt_d    = cnt_q + 1'b1;
      idx_d    = idx_q;
      nibble_d = nibble_q;
      blank_d  = blank_q;
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
         // Inputs are sampled only here, for the digit whose slot is starting.
         for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (idx_d == IW'(k)) begin
               nibble_d = digits[4*k +: 4];
               blank_d  = blank_eff[k];
            end
         end
      end
   end

   // Reset parks the scan on the last cycle of the last digit so the first
   // edge after release starts slot 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= CNT_LAST;
         idx_q    <= IDX_LAST;
         nibble_q <= '0;
         blank_q  <= 1'b1;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         nibble_q <= nibble_d;
         blank_q  <= blank_d;
      end
   end

   generate
      if (DEAD_CYCLES == 0) begin : g_no_dead
         assign dead_done = 1'b1;
      end else begin : g_dead
         assign dead_done = (cnt_q >= CW'(DEAD_CYCLES));
      end
   endgenerate

   assign active = dead_done & ~blank_q;

   seven_seg_decoder u_decoder (
      .nibble (nibble_q),
      .seg    (seg_dec)
   );

   always_comb begin
      seg   = SEG_OFF;
      anode = '1;
      if (active) begin
         seg   = seg_dec;
         anode = ~(NUM_DIGITS'(1) << idx_q);
      end
   end

   assign frame = (idx_q == '0) && (cnt_q == '0);

endmodule

// File: tb/tb_seven_seg_mux.sv
// Directed bench for seven_seg_mux with NUM_DIGITS=2, SLOT_CYCLES=8, DEAD_CYCLES=2.
module tb_seven_seg_mux;

   localparam int unsigned N = 2;
   localparam int unsigned S = 8;
   localparam int unsigned D = 2;

`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   logic           clk;
   logic           reset;
   logic [4*N-1:0] digits;
   logic [N-1:0]   blank;
   logic [6:0]     seg;
   logic [N-1:0]   anode;
   logic           frame;

   int checks;
   int errors;

   seven_seg_mux #(
      .NUM_DIGITS  (N),
      .SLOT_CYCLES (S),
      .DEAD_CYCLES (D)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .digits (digits),
      .blank  (blank),
      .seg    (seg),
      .anode  (anode),
      .frame  (frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_dark(input string tag, input logic exp_frame);
      check_eq({tag, " anode"}, 32'(anode), 32'(2'b11));
      check_eq({tag, " seg"},   32'(seg),   32'h7F);
      check_eq({tag, " frame"}, 32'(frame), 32'(exp_frame));
   endtask

   // Called at the negedge where cnt==0 of the given slot; checks ncyc cycles and
   // optionally changes inputs after the check at cycle chg_cyc.
   task automatic check_slot(input int slot, input logic [1:0] lit_anode,
                             input logic [6:0] lit_seg, input int chg_cyc,
                             input logic [7:0] chg_dig, input logic [1:0] chg_blank,
                             input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         string tag;
         tag = $sformatf("s%0d c%0d", slot, c);
         check_eq({tag, " anode"}, 32'(anode), (c >= int'(D)) ? 32'(lit_anode) : 32'(2'b11));
         check_eq({tag, " seg"},   32'(seg),   (c >= int'(D)) ? 32'(lit_seg)   : 32'h7F);
         check_eq({tag, " frame"}, 32'(frame), (slot == 0 && c == 0) ? 32'd1 : 32'd0);
         if (c == chg_cyc) begin
            digits = chg_dig;
            blank  = chg_blank;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      digits = 8'h3A;
      blank  = 2'b00;

      repeat (3) begin
         @(negedge clk);
         check_dark("reset", 1'b0);
      end
      reset = 1'b0;
      #1;
      check_dark("release", 1'b0);
      @(negedge clk);

      // Plain scan of 8'h3A over two frames.
      check_slot(0, 2'b10, 7'h08, -1, 8'h00, 2'b00, 8);
      check_slot(1, 2'b01, 7'h30, -1, 8'h00, 2'b00, 8);
      check_slot(0, 2'b10, 7'h08, -1, 8'h00, 2'b00, 8);
      check_slot(1, 2'b01, 7'h30, -1, 8'h00, 2'b00, 8);

      // Mid-slot change to 8'h81 only takes effect at later slot starts.
      check_slot(0, 2'b10, 7'h08, 4, 8'h81, 2'b00, 8);
      check_slot(1, 2'b01, 7'h00, -1, 8'h00, 2'b00, 8);
      check_slot(0, 2'b10, 7'h79, 3, 8'h3A, 2'b10, 8);

      // Digit 1 blanked.
      check_slot(1, 2'b11, 7'h7F, -1, 8'h00, 2'b00, 8);
      check_slot(0, 2'b10, 7'h08, 3, 8'h05, 2'b00, 8);

      // Leading zero handling for 8'h05 then 8'h00.
      check_slot(1, LZ ? 2'b11 : 2'b01, LZ ? 7'h7F : 7'h40, -1, 8'h00, 2'b00, 8);
      check_slot(0, 2'b10, 7'h12, 3, 8'h00, 2'b00, 8);
      check_slot(1, LZ ? 2'b11 : 2'b01, LZ ? 7'h7F : 7'h40, -1, 8'h00, 2'b00, 8);
      check_slot(0, 2'b10, 7'h40, -1, 8'h00, 2'b00, 8);

      // Reset mid-slot 1 at cnt=5.
      check_slot(1, LZ ? 2'b11 : 2'b01, LZ ? 7'h7F : 7'h40, -1, 8'h00, 2'b00, 5);
      reset = 1'b1;
      @(negedge clk);
      check_dark("midreset", 1'b0);
      reset = 1'b0;
      @(negedge clk);
      check_slot(0, 2'b10, 7'h40, -1, 8'h00, 2'b00, 8);
      check_slot(1, LZ ? 2'b11 : 2'b01, LZ ? 7'h7F : 7'h40, -1, 8'h00, 2'b00, 8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
